// File: rtl/xbar_slave_mem_pkg.sv
// Shared definitions for the crossbar slave memory endpoint.
// Contents:
//   ADDR_WIDTH        default crossbar address width
//   cmd_t             request command encoding (read / write)
//   slave_mem_state_t request-handling FSM states of the slave endpoint
package connection_to_cross_bar_module;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_t;

  typedef enum logic [1:0] {
    enIDLE     = 2'd0,
    enWAIT_ACK = 2'd1,
    enACK      = 2'd2
  } slave_mem_state_t;

endpackage

// File: rtl/xbar_slave_mem_resp_delay_line.sv
// resp_delay_line: DEPTH-stage shift register of {valid, data}.
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high clear of every stage
//   in_valid  stage-0 valid input
//   in_data   stage-0 data input
//   out_valid valid of the last stage
//   out_data  data of the last stage; holds its last valid value
module resp_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             valid_in;
      logic [WIDTH-1:0] data_in;

      if (gi == 0) begin : g_first
        assign valid_in = in_valid;
        assign data_in  = in_data;
      end else begin : g_next
        assign valid_in = g_stage[gi-1].valid_reg;
        assign data_in  = g_stage[gi-1].data_reg;
      end

      // Data only moves along with a valid token, so the last stage keeps
      // the most recent response data while nothing new arrives.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_in;
          if (valid_in) begin
            data_reg <= data_in;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].valid_reg;
  assign out_data  = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/xbar_slave_mem.sv
// xbar_slave_mem: memory-backed slave terminating one crossbar slave port.
// Single-beat read/write requests are acknowledged ACK_DELAY cycles after
// req first rises; read data appears on resp/rdata RESP_DELAY cycles after
// the read ack.
// Ports:
//   clk    clock, all logic on posedge
//   rst    synchronous active-high reset
//   req    request valid, held with addr/cmd/wdata stable until ack
//   addr   byte address (MSB is the crossbar slave select, ignored)
//   cmd    0 = read, 1 = write
//   wdata  write data
//   ack    one-cycle request accept pulse
//   resp   one-cycle read-data valid pulse
//   rdata  read data, meaningful when resp = 1
module xbar_slave_mem
  import connection_to_cross_bar_module::*;
#(
  parameter int ADDR_WIDTH = connection_to_cross_bar_module::ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int ACK_DELAY  = 2,
  parameter int RESP_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  cmd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  resp,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  slave_mem_state_t      state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg;
  cmd_t                  cmd_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  ack_reg;
  logic                  rd_valid_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  do_write;
  logic                  do_read;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte offset and bits above the word index (including the slave select)
  // take no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0]};

  // The IDLE cycle that first sees req counts as the first delay cycle, so
  // the ack state is entered exactly ACK_DELAY cycles after req rises.
  // With ACK_DELAY = 1 there is no waiting to do and IDLE goes straight to ACK.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      enIDLE: begin
        if (req) begin
          cnt_next   = CNT_W'(ACK_DELAY - 1);
          state_next = (ACK_DELAY == 1) ? enACK : enWAIT_ACK;
        end
      end
      enWAIT_ACK: begin
        if (!req) begin
          state_next = enIDLE;
        end else if (cnt_reg <= CNT_W'(1)) begin
          state_next = enACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      enACK: begin
        state_next = enIDLE;
      end
      default: begin
        state_next = enIDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= enIDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      idx_reg   <= '0;
      cmd_reg   <= CMD_READ;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= (state_next == enACK);
      if (state_reg == enIDLE && req) begin
        idx_reg   <= addr[IDX_W+1:2];
        cmd_reg   <= cmd_t'(cmd);
        wdata_reg <= wdata;
      end
    end
  end

  assign do_write = (state_reg == enACK) && (cmd_reg == CMD_WRITE);
  assign do_read  = (state_reg == enACK) && (cmd_reg == CMD_READ);

  // Memory contents survive reset; only a write in progress is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  // Registered read port: this register is response stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= do_read;
      if (do_read) begin
        rd_data_reg <= mem[idx_reg];
      end
    end
  end

  generate
    if (RESP_DELAY == 1) begin : g_no_delay
      assign resp  = rd_valid_reg;
      assign rdata = rd_data_reg;
    end else begin : g_delay
      resp_delay_line #(
        .DEPTH(RESP_DELAY - 1),
        .WIDTH(DATA_WIDTH)
      ) u_resp_delay_line (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_valid_reg),
        .in_data  (rd_data_reg),
        .out_valid(resp),
        .out_data (rdata)
      );
    end
  endgenerate

  assign ack = ack_reg;

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Testbench for xbar_slave_mem. Three instances cover three parameter sets:
//   dut 0: ACK_DELAY=2 RESP_DELAY=1 (defaults)
//   dut 1: ACK_DELAY=3 RESP_DELAY=1
//   dut 2: ACK_DELAY=1 RESP_DELAY=4
module tb_xbar_slave_mem;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        req   [3];
  logic [31:0] addr  [3];
  logic        cmd   [3];
  logic [31:0] wdata [3];
  logic        ack   [3];
  logic        resp  [3];
  logic [31:0] rdata [3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  xbar_slave_mem #(.ACK_DELAY(2), .RESP_DELAY(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .addr(addr[0]), .cmd(cmd[0]),
    .wdata(wdata[0]), .ack(ack[0]), .resp(resp[0]), .rdata(rdata[0]));

  xbar_slave_mem #(.ACK_DELAY(3), .RESP_DELAY(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .addr(addr[1]), .cmd(cmd[1]),
    .wdata(wdata[1]), .ack(ack[1]), .resp(resp[1]), .rdata(rdata[1]));

  xbar_slave_mem #(.ACK_DELAY(1), .RESP_DELAY(4)) u_dut2 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .addr(addr[2]), .cmd(cmd[2]),
    .wdata(wdata[2]), .ack(ack[2]), .resp(resp[2]), .rdata(rdata[2]));

  // Move to 1 time unit after the next rising edge: outputs of the new
  // cycle are settled and inputs written now are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request starting in the current cycle and watch for 12 cycles.
  // Offsets are counted in cycles from the cycle req was raised.
  task automatic run_req(input int k, input logic [31:0] a, input logic c,
                         input logic [31:0] d, output int ack_at,
                         output int ack_n, output int resp_at,
                         output int resp_n, output logic [31:0] rd);
    addr[k]  = a;
    cmd[k]   = c;
    wdata[k] = d;
    req[k]   = 1'b1;
    ack_at   = -1;
    ack_n    = 0;
    resp_at  = -1;
    resp_n   = 0;
    rd       = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack[k] === 1'b1) begin
        ack_n++;
        if (ack_at < 0) ack_at = i;
        req[k] = 1'b0;
      end
      if (resp[k] === 1'b1) begin
        resp_n++;
        if (resp_at < 0) begin
          resp_at = i;
          rd      = rdata[k];
        end
      end
    end
    req[k] = 1'b0;
    $display("txn dut%0d cmd=%0d addr=%h wdata=%h ack@%0d acks=%0d resp@%0d resps=%0d rdata=%h",
             k, c, a, d, ack_at, ack_n, resp_at, resp_n, rd);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; cmd[k] = 1'b0; wdata[k] = '0;
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ack[k] !== 1'b0) begin
        errors++; $display("FAIL reset_ack dut%0d: got %b expected 0", k, ack[k]);
      end
      vectors++;
      if (resp[k] !== 1'b0) begin
        errors++; $display("FAIL reset_resp dut%0d: got %b expected 0", k, resp[k]);
      end
      vectors++;
      if (rdata[k] !== 32'h0) begin
        errors++; $display("FAIL reset_rdata dut%0d: got %h expected 0", k, rdata[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int aa, an, ra, rn; logic [31:0] rd; int ack_seen;
    run_req(0, 32'h20, 1'b1, 32'h11, aa, an, ra, rn, rd);
    vectors++;
    if (aa !== 2) begin errors++; $display("FAIL rmid_wr_ack_at: got %0d expected 2", aa); end
    run_req(0, 32'h20, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (rd !== 32'h11) begin errors++; $display("FAIL rmid_pre_read: got %h expected 00000011", rd); end
    // Start a write, then reset for two cycles while it waits for ack.
    addr[0] = 32'h20; cmd[0] = 1'b1; wdata[0] = 32'h55; req[0] = 1'b1;
    tick();
    rst[0] = 1'b1; req[0] = 1'b0;
    ack_seen = 0;
    tick(); if (ack[0] === 1'b1) ack_seen++;
    tick(); if (ack[0] === 1'b1) ack_seen++;
    rst[0] = 1'b0;
    vectors++;
    if (ack_seen !== 0) begin errors++; $display("FAIL rmid_ack_in_reset: got %0d expected 0", ack_seen); end
    vectors++;
    if (ack[0] !== 1'b0) begin errors++; $display("FAIL rmid_ack: got %b expected 0", ack[0]); end
    vectors++;
    if (resp[0] !== 1'b0) begin errors++; $display("FAIL rmid_resp: got %b expected 0", resp[0]); end
    vectors++;
    if (rdata[0] !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h expected 0", rdata[0]); end
    run_req(0, 32'h20, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (rd !== 32'h11) begin errors++; $display("FAIL rmid_no_write: got %h expected 00000011", rd); end
    vectors++;
    if (ra !== 3) begin errors++; $display("FAIL rmid_resp_at: got %0d expected 3", ra); end
  endtask

  task automatic test_write_read();
    int aa, an, ra, rn; logic [31:0] rd;
    run_req(0, 32'h10, 1'b1, 32'hDEADBEEF, aa, an, ra, rn, rd);
    vectors++;
    if (aa !== 2) begin errors++; $display("FAIL wr_ack_at: got %0d expected 2", aa); end
    vectors++;
    if (an !== 1) begin errors++; $display("FAIL wr_ack_count: got %0d expected 1", an); end
    vectors++;
    if (rn !== 0) begin errors++; $display("FAIL wr_no_resp: got %0d expected 0", rn); end
    run_req(0, 32'h10, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (aa !== 2) begin errors++; $display("FAIL rd_ack_at: got %0d expected 2", aa); end
    vectors++;
    if (ra !== 3) begin errors++; $display("FAIL rd_resp_at: got %0d expected 3", ra); end
    vectors++;
    if (rn !== 1) begin errors++; $display("FAIL rd_resp_count: got %0d expected 1", rn); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_alias();
    int aa, an, ra, rn; logic [31:0] rd;
    run_req(0, 32'h80000004, 1'b1, 32'h1234, aa, an, ra, rn, rd);
    run_req(0, 32'h00000008, 1'b1, 32'h5678, aa, an, ra, rn, rd);
    run_req(0, 32'h00000004, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (rd !== 32'h1234) begin errors++; $display("FAIL alias_0x4: got %h expected 00001234", rd); end
    run_req(0, 32'h00000404, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (rd !== 32'h1234) begin errors++; $display("FAIL alias_0x404: got %h expected 00001234", rd); end
    run_req(0, 32'h00000009, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (rd !== 32'h5678) begin errors++; $display("FAIL alias_byteoff: got %h expected 00005678", rd); end
  endtask

  task automatic test_abort();
    int aa, an, ra, rn; logic [31:0] rd; int ack_seen;
    run_req(1, 32'h30, 1'b1, 32'hCAFE, aa, an, ra, rn, rd);
    vectors++;
    if (aa !== 3) begin errors++; $display("FAIL abort_pre_ack_at: got %0d expected 3", aa); end
    addr[1] = 32'h30; cmd[1] = 1'b1; wdata[1] = 32'hBAD; req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack[1] === 1'b1) ack_seen++;
    end
    vectors++;
    if (ack_seen !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d expected 0", ack_seen); end
    run_req(1, 32'h30, 1'b0, 32'h0, aa, an, ra, rn, rd);
    vectors++;
    if (aa !== 3) begin errors++; $display("FAIL abort_next_ack_at: got %0d expected 3", aa); end
    vectors++;
    if (rd !== 32'hCAFE) begin errors++; $display("FAIL abort_mem: got %h expected 0000cafe", rd); end
  endtask

  task automatic test_back_to_back();
    int aa, an, ra, rn; logic [31:0] rd;
    int ack_t [2]; int resp_t [2]; logic [31:0] resp_d [2]; int na, nr;
    run_req(2, 32'h0, 1'b1, 32'hA, aa, an, ra, rn, rd);
    vectors++;
    if (aa !== 1) begin errors++; $display("FAIL b2b_wr_ack_at: got %0d expected 1", aa); end
    run_req(2, 32'h4, 1'b1, 32'hB, aa, an, ra, rn, rd);
    na = 0; nr = 0;
    ack_t = '{-1, -1}; resp_t = '{-1, -1}; resp_d = '{32'h0, 32'h0};
    addr[2] = 32'h0; cmd[2] = 1'b0; req[2] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack[2] === 1'b1) begin
        if (na < 2) ack_t[na] = i;
        na++;
        if (na == 1) addr[2] = 32'h4;
        else req[2] = 1'b0;
      end
      if (resp[2] === 1'b1) begin
        if (nr < 2) begin resp_t[nr] = i; resp_d[nr] = rdata[2]; end
        nr++;
      end
    end
    req[2] = 1'b0;
    $display("txn dut2 b2b reads acks@%0d,%0d resps@%0d,%0d rdata=%h,%h",
             ack_t[0], ack_t[1], resp_t[0], resp_t[1], resp_d[0], resp_d[1]);
    vectors++;
    if (na !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", na); end
    vectors++;
    if (ack_t[0] !== 1 || ack_t[1] !== 3) begin
      errors++; $display("FAIL b2b_ack_at: got %0d,%0d expected 1,3", ack_t[0], ack_t[1]);
    end
    vectors++;
    if (nr !== 2) begin errors++; $display("FAIL b2b_resp_count: got %0d expected 2", nr); end
    vectors++;
    if (resp_t[0] !== 5 || resp_t[1] !== 7) begin
      errors++; $display("FAIL b2b_resp_at: got %0d,%0d expected 5,7", resp_t[0], resp_t[1]);
    end
    vectors++;
    if (resp_d[0] !== 32'hA || resp_d[1] !== 32'hB) begin
      errors++; $display("FAIL b2b_rdata: got %h,%h expected 0000000a,0000000b", resp_d[0], resp_d[1]);
    end
  endtask

  task automatic test_reset_inflight();
    int na, nr;
    na = 0; nr = 0;
    addr[2] = 32'h0; cmd[2] = 1'b0; req[2] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (rst[2] === 1'b1) rst[2] = 1'b0;
      if (ack[2] === 1'b1) begin
        na++;
        if (na == 1) addr[2] = 32'h4;
        else begin
          // Second read is in its ack cycle, first is in the pipeline.
          req[2] = 1'b0;
          rst[2] = 1'b1;
        end
      end
      if (resp[2] === 1'b1) nr++;
    end
    req[2] = 1'b0;
    rst[2] = 1'b0;
    $display("txn dut2 reset with reads in flight acks=%0d resps=%0d", na, nr);
    vectors++;
    if (na !== 2) begin errors++; $display("FAIL inflight_ack_count: got %0d expected 2", na); end
    vectors++;
    if (nr !== 0) begin errors++; $display("FAIL inflight_no_resp: got %0d expected 0", nr); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_read();
    test_alias();
    test_abort();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
